// File: rtl/multicycle_control.sv
// multicycle_control: sequences each instruction through FETCH, DECODE, EXEC,
// MEM and WB, driving datapath strobes decoded from the current state and the
// latched opcode. MEM waits on mem_ready with an optional timeout, retired
// instructions are counted (wrapping), and HALT is terminal until reset.
module multicycle_control #(
  parameter int INSTR_W     = 9,
  parameter int OPC_W       = 3,
  parameter int OPC_LW      = 5,
  parameter int OPC_SW      = 6,
  parameter int OPC_BR      = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               ir_load,
  output logic               pc_en,
  output logic               write_enable,
  output logic [OPC_W-1:0]   alu_op,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               mem_to_reg,
  output logic               busy,
  output logic               halted,
  output logic               err_illegal,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   retired
);

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int NUM_OPC = 1 << OPC_W;

  localparam logic [OPC_W-1:0]  OPC_LW_C  = OPC_W'(OPC_LW);
  localparam logic [OPC_W-1:0]  OPC_SW_C  = OPC_W'(OPC_SW);
  localparam logic [OPC_W-1:0]  OPC_BR_C  = OPC_W'(OPC_BR);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_reg;
  logic [INSTR_W-1:0]  ir_reg;
  logic [WAIT_W-1:0]   wait_reg;
  logic [CNT_W-1:0]    retired_reg;

  logic [OPC_W-1:0]    opc;
  logic [NUM_OPC-1:0]  legal_tab;
  logic                is_lw;
  logic                is_sw;
  logic                is_br;
  logic                is_legal;
  logic                mem_timeout;
  logic                unused_operand;

  assign opc = ir_reg[INSTR_W-1 -: OPC_W];

  // Operand bits are consumed by the datapath, not by this controller.
  assign unused_operand = ^ir_reg[INSTR_W-OPC_W-1:0];

  // Legality table: ALU opcodes below OPC_LW plus the three explicit opcodes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPC; gi++) begin : g_legal
      assign legal_tab[gi] = (gi < OPC_LW) || (gi == OPC_LW) ||
                             (gi == OPC_SW) || (gi == OPC_BR);
    end
  endgenerate

  // Opcode classification; an unknown opcode fails the if and reads as illegal.
  always_comb begin
    is_lw    = (opc == OPC_LW_C);
    is_sw    = (opc == OPC_SW_C);
    is_br    = (opc == OPC_BR_C);
    is_legal = 1'b0;
    if (legal_tab[opc]) begin
      is_legal = 1'b1;
    end
  end

  // Timeout fires on the last permitted wait cycle only if memory is still not ready.
  always_comb begin
    mem_timeout = 1'b0;
    if ((MEM_TIMEOUT != 0) && !mem_ready && (wait_reg == WAIT_LAST)) begin
      mem_timeout = 1'b1;
    end
  end

  // Instruction sequencer: state, IR, MEM wait counter and retire counter.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_reg   <= S_FETCH;
      ir_reg      <= '0;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (halt_req) begin
            state_reg <= S_HALT;
          end else if (instr_valid) begin
            ir_reg    <= instruction;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (is_br) begin
            retired_reg <= retired_reg + CNT_W'(1);
            state_reg   <= S_FETCH;
          end else if (is_lw || is_sw) begin
            wait_reg  <= '0;
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_lw) begin
              state_reg <= S_WB;
            end else begin
              retired_reg <= retired_reg + CNT_W'(1);
              state_reg   <= S_FETCH;
            end
          end else if (mem_timeout) begin
            state_reg <= S_FETCH;
          end else if (MEM_TIMEOUT != 0) begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_reg <= retired_reg + CNT_W'(1);
          state_reg   <= S_FETCH;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  // Strobe decode from state and latched opcode; ir_load is masked during reset.
  always_comb begin
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    write_enable = 1'b0;
    alu_op       = '0;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    mem_to_reg   = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    err_illegal  = 1'b0;
    err_timeout  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_load = init_n & instr_valid & ~halt_req;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (!is_legal) begin
          err_illegal = 1'b1;
          pc_en       = 1'b1;
        end
      end
      S_EXEC: begin
        busy   = 1'b1;
        alu_op = opc;
        if (is_br) begin
          branch = 1'b1;
          pc_en  = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
        end
      end
      S_MEM: begin
        busy      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          pc_en = is_sw;
        end else if (mem_timeout) begin
          pc_en       = 1'b1;
          err_timeout = 1'b1;
        end
      end
      S_WB: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        pc_en        = 1'b1;
        mem_to_reg   = is_lw;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instance A uses default parameters, instance B
// uses a 4-bit opcode (illegal opcodes exist), no MEM timeout and a 2-bit
// retire counter. Expected per-cycle strobes come from an instruction-level
// list of phases built from the opcode class and memory delay.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       init_a, init_b;
  logic [8:0] instr_a;
  logic [9:0] instr_b;
  logic       instr_valid, mem_ready, halt_req;

  logic       a_ir_load, a_pc_en, a_we, a_alu_src, a_mrd, a_mwr, a_br, a_m2r;
  logic       a_busy, a_halted, a_eill, a_eto;
  logic [2:0] a_alu_op;
  logic [15:0] a_retired;

  logic       b_ir_load, b_pc_en, b_we, b_alu_src, b_mrd, b_mwr, b_br, b_m2r;
  logic       b_busy, b_halted, b_eill, b_eto;
  logic [3:0] b_alu_op;
  logic [1:0] b_retired;

  multicycle_control dut_a (
    .clk(clk), .init_n(init_a), .instruction(instr_a), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .halt_req(halt_req), .ir_load(a_ir_load), .pc_en(a_pc_en),
    .write_enable(a_we), .alu_op(a_alu_op), .alu_src(a_alu_src), .mem_read(a_mrd),
    .mem_write(a_mwr), .branch(a_br), .mem_to_reg(a_m2r), .busy(a_busy),
    .halted(a_halted), .err_illegal(a_eill), .err_timeout(a_eto), .retired(a_retired)
  );

  multicycle_control #(
    .INSTR_W(10), .OPC_W(4), .OPC_LW(5), .OPC_SW(6), .OPC_BR(7),
    .MEM_TIMEOUT(0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .init_n(init_b), .instruction(instr_b), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .halt_req(halt_req), .ir_load(b_ir_load), .pc_en(b_pc_en),
    .write_enable(b_we), .alu_op(b_alu_op), .alu_src(b_alu_src), .mem_read(b_mrd),
    .mem_write(b_mwr), .branch(b_br), .mem_to_reg(b_m2r), .busy(b_busy),
    .halted(b_halted), .err_illegal(b_eill), .err_timeout(b_eto), .retired(b_retired)
  );

  localparam logic [11:0] M_IRL  = 12'h800;
  localparam logic [11:0] M_PC   = 12'h400;
  localparam logic [11:0] M_WE   = 12'h200;
  localparam logic [11:0] M_SRC  = 12'h100;
  localparam logic [11:0] M_RD   = 12'h080;
  localparam logic [11:0] M_WR   = 12'h040;
  localparam logic [11:0] M_BR   = 12'h020;
  localparam logic [11:0] M_M2R  = 12'h010;
  localparam logic [11:0] M_BUSY = 12'h008;
  localparam logic [11:0] M_HALT = 12'h004;
  localparam logic [11:0] M_ILL  = 12'h002;
  localparam logic [11:0] M_TO   = 12'h001;

  typedef struct packed {
    logic [11:0] stb;
    logic        chk_op;
    logic        is_mem;
    logic        rdy;
  } cyc_t;

  int errors = 0;
  int checks = 0;
  int exp_ret [2];

  function automatic logic [11:0] obs_stb(input int sel);
    if (sel == 0)
      return {a_ir_load, a_pc_en, a_we, a_alu_src, a_mrd, a_mwr, a_br, a_m2r,
              a_busy, a_halted, a_eill, a_eto};
    return {b_ir_load, b_pc_en, b_we, b_alu_src, b_mrd, b_mwr, b_br, b_m2r,
            b_busy, b_halted, b_eill, b_eto};
  endfunction

  function automatic logic [3:0] obs_op(input int sel);
    if (sel == 0) return {1'b0, a_alu_op};
    return b_alu_op;
  endfunction

  function automatic logic [15:0] obs_ret(input int sel);
    if (sel == 0) return a_retired;
    return {14'd0, b_retired};
  endfunction

  // One instruction from FETCH back to FETCH, compared cycle by cycle.
  task automatic run_instr(input int sel, input int opc, input int delay);
    cyc_t q[$];
    cyc_t c;
    bit   retire;
    bit   tmo_hit;
    int   tmo;
    int   n;
    logic [11:0] rw;
    logic [3:0]  o4;
    tmo     = (sel == 0) ? 16 : 0;
    retire  = 1'b0;
    tmo_hit = 1'b0;
    o4      = 4'(opc);
    c = '0; c.stb = M_IRL; q.push_back(c);
    if (opc > 7) begin
      c = '0; c.stb = M_BUSY | M_PC | M_ILL; q.push_back(c);
    end else begin
      c = '0; c.stb = M_BUSY; q.push_back(c);
      c = '0; c.stb = M_BUSY; c.chk_op = 1'b1;
      if (opc == 7) begin
        c.stb |= M_BR | M_PC; q.push_back(c); retire = 1'b1;
      end else if (opc < 5) begin
        q.push_back(c);
        c = '0; c.stb = M_BUSY | M_WE | M_PC; q.push_back(c); retire = 1'b1;
      end else begin
        c.stb |= M_SRC; q.push_back(c);
        rw = (opc == 5) ? M_RD : M_WR;
        tmo_hit = (tmo != 0) && (delay >= tmo);
        n = tmo_hit ? tmo : delay + 1;
        for (int k = 0; k < n; k++) begin
          c = '0; c.stb = M_BUSY | rw; c.is_mem = 1'b1;
          c.rdy = !tmo_hit && (k == n - 1);
          if (k == n - 1) begin
            if (tmo_hit) c.stb |= M_PC | M_TO;
            else if (opc == 6) begin c.stb |= M_PC; retire = 1'b1; end
          end
          q.push_back(c);
        end
        if (opc == 5 && !tmo_hit) begin
          c = '0; c.stb = M_BUSY | M_WE | M_PC | M_M2R; q.push_back(c); retire = 1'b1;
        end
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        if (sel == 0) instr_a = {o4[2:0], 6'($urandom)};
        else          instr_b = {o4, 6'($urandom)};
        instr_valid = 1'b1;
        halt_req    = 1'b0;
      end else begin
        instr_a     = 9'($urandom);
        instr_b     = 10'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
        halt_req    = 1'($urandom_range(0, 1));
      end
      mem_ready = q[i].is_mem ? q[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs_stb(sel) !== q[i].stb) begin
        errors++;
        $display("FAIL strobes dut=%0d opc=%0d cyc=%0d got=%b want=%b", sel, opc, i, obs_stb(sel), q[i].stb);
      end
      if (q[i].chk_op) begin
        checks++;
        if (obs_op(sel) !== o4) begin
          errors++;
          $display("FAIL alu_op dut=%0d got=%0d want=%0d", sel, obs_op(sel), o4);
        end
      end
      checks++;
      if (obs_ret(sel) !== 16'(exp_ret[sel])) begin
        errors++;
        $display("FAIL retired dut=%0d opc=%0d cyc=%0d got=%0d want=%0d", sel, opc, i, obs_ret(sel), exp_ret[sel]);
      end
      @(posedge clk); #1;
    end
    if (retire) exp_ret[sel] = (exp_ret[sel] + 1) % ((sel == 0) ? 65536 : 4);
    instr_valid = 1'b0;
    halt_req    = 1'b0;
    mem_ready   = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (obs_stb(sel) !== 12'd0 || obs_ret(sel) !== 16'(exp_ret[sel])) begin
      errors++;
      $display("FAIL idle dut=%0d opc=%0d stb=%b want=0 retired=%0d want=%0d", sel, opc, obs_stb(sel), obs_ret(sel), exp_ret[sel]);
    end
    $display("txn dut=%0d opc=%0d delay=%0d cycles=%0d timeout=%0d retired=%0d", sel, opc, delay, q.size(), tmo_hit, exp_ret[sel]);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    instr_a = 9'b100_000_000; instr_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_stb(0) !== 12'd0 || obs_op(0) !== 4'd0 || obs_ret(0) !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs stb=%b op=%0d retired=%0d want all 0", obs_stb(0), obs_op(0), obs_ret(0));
    end
    @(posedge clk); #1;
    init_a = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_stb(0) !== 12'd0) begin
      errors++;
      $display("FAIL reset_release stb=%b want 0", obs_stb(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    run_instr(0, 4, 0);
    run_instr(0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(0, 5, 3);
    run_instr(0, 5, 0);
  endtask

  task automatic test_sw_timeout();
    run_instr(0, 6, 100);
    run_instr(0, 6, 15);
    run_instr(0, 5, 16);
  endtask

  task automatic test_br();
    run_instr(0, 7, 0);
  endtask

  task automatic test_random_a();
    for (int t = 0; t < 25; t++) begin
      int opc;
      int d;
      opc = $urandom_range(0, 7);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      run_instr(0, opc, d);
    end
  endtask

  task automatic test_reset_mid_mem();
    instr_a = 9'b101_000_000; instr_valid = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (obs_stb(0) !== (M_BUSY | M_RD)) begin
      errors++;
      $display("FAIL mid_mem_before stb=%b want=%b", obs_stb(0), M_BUSY | M_RD);
    end
    #2 init_a = 1'b0; instr_valid = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (obs_stb(0) !== 12'd0 || obs_ret(0) !== 16'd0) begin
      errors++;
      $display("FAIL mid_mem_reset stb=%b retired=%0d want 0 and 0", obs_stb(0), obs_ret(0));
    end
    @(posedge clk); #1;
    init_a = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    exp_ret[0] = 0;
    $display("txn dut=0 reset during MEM, retired cleared");
    run_instr(0, 4, 0);
  endtask

  task automatic test_halt();
    instr_a = 9'b100_000_000; instr_valid = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_stb(0) !== 12'd0) begin
      errors++;
      $display("FAIL halt_fetch stb=%b want 0 (no ir_load)", obs_stb(0));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      halt_req    = 1'($urandom_range(0, 1));
      mem_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs_stb(0) !== M_HALT || obs_ret(0) !== 16'(exp_ret[0])) begin
        errors++;
        $display("FAIL halt_hold cyc=%0d stb=%b want=%b retired=%0d want=%0d", i, obs_stb(0), M_HALT, obs_ret(0), exp_ret[0]);
      end
      @(posedge clk); #1;
    end
    $display("txn dut=0 halt entered and held");
    instr_valid = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_illegal();
    for (int opc = 8; opc < 16; opc++) run_instr(1, opc, 0);
  endtask

  task automatic test_wrap();
    for (int t = 0; t < 5; t++) run_instr(1, $urandom_range(0, 4), 0);
    checks++;
    if (obs_ret(1) !== 16'd1) begin
      errors++;
      $display("FAIL wrap retired=%0d want=1", obs_ret(1));
    end
  endtask

  task automatic test_no_timeout();
    run_instr(1, 5, 20);
    run_instr(1, 6, 25);
  endtask

  task automatic test_random_b();
    for (int t = 0; t < 20; t++) run_instr(1, $urandom_range(0, 15), $urandom_range(0, 6));
  endtask

  initial begin
    init_a = 1'b0; init_b = 1'b0;
    instr_a = '0; instr_b = '0;
    instr_valid = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    exp_ret[0] = 0; exp_ret[1] = 0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw_timeout();
    test_br();
    test_random_a();
    test_reset_mid_mem();
    test_halt();
    init_a = 1'b0;
    init_b = 1'b1;
    @(posedge clk); #1;
    test_illegal();
    test_wrap();
    test_no_timeout();
    test_random_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
